// File: rtl/calc2_pkg.sv
// Shared types and sizing for the calc2 port driver slice.
package calc2_pkg;

    localparam int unsigned N_TAGS = 4;
    localparam int unsigned TAG_W  = 2;
    localparam int unsigned CMD_W  = 4;
    localparam int unsigned CNT_W  = 3;

    typedef enum logic [CMD_W-1:0] {
        CMD_NOP = 4'd0,
        CMD_ADD = 4'd1,
        CMD_SUB = 4'd2,
        CMD_SHL = 4'd5,
        CMD_SHR = 4'd6
    } cmd_e;

    typedef enum logic [1:0] {
        RESP_NONE = 2'd0,
        RESP_OK   = 2'd1,
        RESP_OVF  = 2'd2,
        RESP_INV  = 2'd3
    } resp_e;

    typedef logic [TAG_W-1:0] tag_t;

endpackage

// File: rtl/calc2_tag_pool.sv
// Free-tag bookkeeping: free vector, lowest-free encoder and outstanding count.
module calc2_tag_pool
    import calc2_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              alloc_i,
    input  logic              free_i,
    input  logic [1:0]        free_tag_i,
    output logic              any_free_c_o,
    output logic [1:0]        alloc_tag_c_o,
    output logic [N_TAGS-1:0] free_vec_o,
    output logic [2:0]        cnt_o
);

    logic [N_TAGS-1:0] free_q, free_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    tag_t              alloc_tag_c;

    // Lowest-numbered free tag wins.
    always_comb begin
        alloc_tag_c = '0;
        for (int i = int'(N_TAGS) - 1; i >= 0; i--) begin
            if (free_q[i]) alloc_tag_c = TAG_W'(i);
        end
    end

    always_comb begin
        free_d = free_q;
        cnt_d  = cnt_q;
        if (alloc_i) free_d[alloc_tag_c] = 1'b0;
        if (free_i)  free_d[free_tag_i]  = 1'b1;
        case ({alloc_i, free_i})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            free_q <= '1;
            cnt_q  <= '0;
        end else begin
            free_q <= free_d;
            cnt_q  <= cnt_d;
        end
    end

    assign any_free_c_o  = |free_q;
    assign alloc_tag_c_o = alloc_tag_c;
    assign free_vec_o    = free_q;
    assign cnt_o         = cnt_q;

endmodule

// File: rtl/calc2_port_driver.sv
// Issues whole operations as calc2 two-beat requests and retires tags on response.
module calc2_port_driver #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned N_TAGS = 4
) (
    input  logic              c_clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_cmd,
    input  logic [DATA_W-1:0] in_op1,
    input  logic [DATA_W-1:0] in_op2,
    output logic [3:0]        req_cmd_in,
    output logic [DATA_W-1:0] req_data_in,
    output logic [1:0]        req_tag_in,
    input  logic [1:0]        out_resp,
    input  logic [DATA_W-1:0] out_data,
    input  logic [1:0]        out_tag,
    output logic              cpl_valid,
    output logic [1:0]        cpl_resp,
    output logic [DATA_W-1:0] cpl_data,
    output logic [1:0]        cpl_tag,
    output logic [3:0]        cpl_cmd,
    output logic [2:0]        busy_cnt,
    output logic              err_unexp
);
    import calc2_pkg::*;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_BEAT1 = 2'd1;
    localparam logic [1:0] ST_BEAT2 = 2'd2;

    logic [1:0]        state_q, state_d;
    logic              run_q;
    logic [3:0]        req_cmd_q, req_cmd_d;
    logic [DATA_W-1:0] req_data_q, req_data_d;
    tag_t              req_tag_q, req_tag_d;
    logic [DATA_W-1:0] op2_q, op2_d;
    logic [3:0]        cmd_tab_q [N_TAGS];

    logic              cpl_valid_q, cpl_valid_d;
    logic [1:0]        cpl_resp_q, cpl_resp_d;
    logic [DATA_W-1:0] cpl_data_q, cpl_data_d;
    tag_t              cpl_tag_q, cpl_tag_d;
    logic [3:0]        cpl_cmd_q, cpl_cmd_d;
    logic              err_q, err_d;

    logic              any_free_c;
    tag_t              alloc_tag_c;
    logic [N_TAGS-1:0] free_vec;
    logic [2:0]        busy_cnt_w;
    logic              in_ready_c, accept_c, issue_c;
    logic              resp_seen_c, resp_hit_c, resp_bad_c;

    calc2_tag_pool u_tag_pool (
        .clk           (c_clk),
        .rst_n         (reset),
        .alloc_i       (issue_c),
        .free_i        (resp_hit_c),
        .free_tag_i    (out_tag),
        .any_free_c_o  (any_free_c),
        .alloc_tag_c_o (alloc_tag_c),
        .free_vec_o    (free_vec),
        .cnt_o         (busy_cnt_w)
    );

    // run_q holds in_ready low while reset is asserted.
    always_comb begin
        in_ready_c  = run_q && (state_q != ST_BEAT1) && any_free_c;
        accept_c    = in_valid && in_ready_c;
        issue_c     = accept_c && (in_cmd != CMD_NOP);
        resp_seen_c = (out_resp != RESP_NONE);
        resp_hit_c  = resp_seen_c && !free_vec[out_tag];
        resp_bad_c  = resp_seen_c && free_vec[out_tag];
    end

    always_comb begin
        state_d    = state_q;
        req_cmd_d  = req_cmd_q;
        req_data_d = req_data_q;
        req_tag_d  = req_tag_q;
        op2_d      = op2_q;
        case (state_q)
            ST_IDLE, ST_BEAT2: begin
                if (issue_c) begin
                    state_d    = ST_BEAT1;
                    req_cmd_d  = in_cmd;
                    req_data_d = in_op1;
                    req_tag_d  = alloc_tag_c;
                    op2_d      = in_op2;
                end else begin
                    state_d    = ST_IDLE;
                    req_cmd_d  = '0;
                    req_data_d = '0;
                    req_tag_d  = '0;
                end
            end
            ST_BEAT1: begin
                state_d    = ST_BEAT2;
                req_cmd_d  = '0;
                req_data_d = op2_q;
            end
            default: begin
                state_d    = ST_IDLE;
                req_cmd_d  = '0;
                req_data_d = '0;
                req_tag_d  = '0;
            end
        endcase
    end

    // Completion capture and sticky unexpected-response flag.
    always_comb begin
        cpl_valid_d = resp_hit_c;
        cpl_resp_d  = cpl_resp_q;
        cpl_data_d  = cpl_data_q;
        cpl_tag_d   = cpl_tag_q;
        cpl_cmd_d   = cpl_cmd_q;
        err_d       = err_q | resp_bad_c;
        if (resp_hit_c) begin
            cpl_resp_d = out_resp;
            cpl_data_d = out_data;
            cpl_tag_d  = out_tag;
            cpl_cmd_d  = cmd_tab_q[out_tag];
        end
    end

    always_ff @(posedge c_clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            run_q       <= 1'b0;
            req_cmd_q   <= '0;
            req_data_q  <= '0;
            req_tag_q   <= '0;
            op2_q       <= '0;
            cpl_valid_q <= 1'b0;
            cpl_resp_q  <= '0;
            cpl_data_q  <= '0;
            cpl_tag_q   <= '0;
            cpl_cmd_q   <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            run_q       <= 1'b1;
            req_cmd_q   <= req_cmd_d;
            req_data_q  <= req_data_d;
            req_tag_q   <= req_tag_d;
            op2_q       <= op2_d;
            cpl_valid_q <= cpl_valid_d;
            cpl_resp_q  <= cpl_resp_d;
            cpl_data_q  <= cpl_data_d;
            cpl_tag_q   <= cpl_tag_d;
            cpl_cmd_q   <= cpl_cmd_d;
            err_q       <= err_d;
        end
    end

    always_ff @(posedge c_clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < int'(N_TAGS); i++) cmd_tab_q[i] <= '0;
        end else if (issue_c) begin
            cmd_tab_q[alloc_tag_c] <= in_cmd;
        end
    end

    assign in_ready    = in_ready_c;
    assign req_cmd_in  = req_cmd_q;
    assign req_data_in = req_data_q;
    assign req_tag_in  = req_tag_q;
    assign cpl_valid   = cpl_valid_q;
    assign cpl_resp    = cpl_resp_q;
    assign cpl_data    = cpl_data_q;
    assign cpl_tag     = cpl_tag_q;
    assign cpl_cmd     = cpl_cmd_q;
    assign busy_cnt    = busy_cnt_w;
    assign err_unexp   = err_q;

endmodule

// File: tb/tb_calc2_port_driver.sv
// Self-checking bench for calc2_port_driver with a completion scoreboard.
module tb_calc2_port_driver;

    localparam int unsigned DW = 32;

    logic          c_clk = 1'b0;
    logic          reset = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [3:0]    in_cmd = '0;
    logic [DW-1:0] in_op1 = '0;
    logic [DW-1:0] in_op2 = '0;
    logic [3:0]    req_cmd_in;
    logic [DW-1:0] req_data_in;
    logic [1:0]    req_tag_in;
    logic [1:0]    out_resp = '0;
    logic [DW-1:0] out_data = '0;
    logic [1:0]    out_tag = '0;
    logic          cpl_valid;
    logic [1:0]    cpl_resp;
    logic [DW-1:0] cpl_data;
    logic [1:0]    cpl_tag;
    logic [3:0]    cpl_cmd;
    logic [2:0]    busy_cnt;
    logic          err_unexp;

    int n_chk  = 0;
    int n_pass = 0;

    typedef struct packed {
        logic [1:0]    resp;
        logic [DW-1:0] data;
        logic [1:0]    tag;
        logic [3:0]    cmd;
    } cpl_t;

    cpl_t cpl_q[$];
    cpl_t mon_got;
    cpl_t mon_exp;

    calc2_port_driver #(.DATA_W(DW), .N_TAGS(4)) dut (
        .c_clk       (c_clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_cmd      (in_cmd),
        .in_op1      (in_op1),
        .in_op2      (in_op2),
        .req_cmd_in  (req_cmd_in),
        .req_data_in (req_data_in),
        .req_tag_in  (req_tag_in),
        .out_resp    (out_resp),
        .out_data    (out_data),
        .out_tag     (out_tag),
        .cpl_valid   (cpl_valid),
        .cpl_resp    (cpl_resp),
        .cpl_data    (cpl_data),
        .cpl_tag     (cpl_tag),
        .cpl_cmd     (cpl_cmd),
        .busy_cnt    (busy_cnt),
        .err_unexp   (err_unexp)
    );

    always #5 c_clk = ~c_clk;

    // Every completion must match the oldest outstanding expectation.
    always @(negedge c_clk) begin
        if (reset && cpl_valid) begin
            mon_got = {cpl_resp, cpl_data, cpl_tag, cpl_cmd};
            n_chk++;
            if (cpl_q.size() == 0) begin
                $display("FAIL cpl_unexpected: got resp=%0d data=%0d tag=%0d cmd=%0d, required no completion",
                         cpl_resp, cpl_data, cpl_tag, cpl_cmd);
            end else begin
                mon_exp = cpl_q.pop_front();
                if (mon_got !== mon_exp)
                    $display("FAIL cpl_fields: got resp=%0d data=%0d tag=%0d cmd=%0d, required resp=%0d data=%0d tag=%0d cmd=%0d",
                             mon_got.resp, mon_got.data, mon_got.tag, mon_got.cmd,
                             mon_exp.resp, mon_exp.data, mon_exp.tag, mon_exp.cmd);
                else
                    n_pass++;
            end
        end
    end

    // Offer one operation, wait (bounded) for accept, capture both bus beats.
    task automatic send_op(input logic [3:0] c, input logic [DW-1:0] a, input logic [DW-1:0] b,
                           output bit acc,
                           output logic [3:0] c1, output logic [DW-1:0] d1, output logic [1:0] t1,
                           output logic [3:0] c2, output logic [DW-1:0] d2, output logic [1:0] t2);
        acc = 1'b0;
        c1 = '0; d1 = '0; t1 = '0; c2 = '0; d2 = '0; t2 = '0;
        in_valid = 1'b1; in_cmd = c; in_op1 = a; in_op2 = b;
        for (int i = 0; i < 20; i++) begin
            if (in_ready) begin
                acc = 1'b1;
                break;
            end
            @(negedge c_clk);
        end
        if (!acc) begin
            in_valid = 1'b0;
            return;
        end
        @(negedge c_clk);
        in_valid = 1'b0;
        c1 = req_cmd_in; d1 = req_data_in; t1 = req_tag_in;
        @(negedge c_clk);
        c2 = req_cmd_in; d2 = req_data_in; t2 = req_tag_in;
    endtask

    task automatic send_resp(input logic [1:0] r, input logic [DW-1:0] d, input logic [1:0] t,
                             input bit expect_cpl, input logic [3:0] ec);
        out_resp = r; out_data = d; out_tag = t;
        if (expect_cpl) cpl_q.push_back({r, d, t, ec});
        @(negedge c_clk);
        out_resp = '0; out_data = '0; out_tag = '0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (2) @(negedge c_clk);
        n_chk++;
        if ({in_ready, req_cmd_in, req_data_in, req_tag_in, cpl_valid, busy_cnt, err_unexp} !== '0)
            $display("FAIL reset_outputs: got ready=%0d cmd=%0d data=%0d tag=%0d cpl=%0d busy=%0d err=%0d, required all 0",
                     in_ready, req_cmd_in, req_data_in, req_tag_in, cpl_valid, busy_cnt, err_unexp);
        else n_pass++;
        reset = 1'b1;
        @(negedge c_clk);
        n_chk++;
        if (in_ready !== 1'b1) $display("FAIL reset_release_ready: got %0d required 1", in_ready);
        else n_pass++;
    endtask

    task automatic test_single_add();
        bit acc;
        logic [3:0] c1, c2; logic [DW-1:0] d1, d2; logic [1:0] t1, t2;
        send_op(4'd1, 32'd5, 32'd7, acc, c1, d1, t1, c2, d2, t2);
        n_chk++;
        if (acc !== 1'b1) $display("FAIL add_accept: got %0d required 1", acc); else n_pass++;
        n_chk++;
        if ({c1, d1, t1} !== {4'd1, 32'd5, 2'd0})
            $display("FAIL add_beat1: got cmd=%0d data=%0d tag=%0d required cmd=1 data=5 tag=0", c1, d1, t1);
        else n_pass++;
        n_chk++;
        if ({c2, d2, t2} !== {4'd0, 32'd7, 2'd0})
            $display("FAIL add_beat2: got cmd=%0d data=%0d tag=%0d required cmd=0 data=7 tag=0", c2, d2, t2);
        else n_pass++;
        n_chk++;
        if (busy_cnt !== 3'd1) $display("FAIL add_busy_during: got %0d required 1", busy_cnt); else n_pass++;
        @(negedge c_clk);
        n_chk++;
        if (req_cmd_in !== 4'd0 || req_data_in !== '0)
            $display("FAIL add_idle_bus: got cmd=%0d data=%0d required 0 0", req_cmd_in, req_data_in);
        else n_pass++;
        send_resp(2'd1, 32'd12, 2'd0, 1'b1, 4'd1);
        n_chk++;
        if (busy_cnt !== 3'd0) $display("FAIL add_busy_after: got %0d required 0", busy_cnt); else n_pass++;
    endtask

    task automatic test_back_to_back();
        in_valid = 1'b1; in_cmd = 4'd1; in_op1 = 32'd10; in_op2 = 32'd20;
        n_chk++;
        if (in_ready !== 1'b1) $display("FAIL b2b_ready0: got %0d required 1", in_ready); else n_pass++;
        for (int i = 0; i < 4; i++) begin
            @(negedge c_clk);
            n_chk++;
            if ({req_cmd_in, req_data_in, req_tag_in} !== {4'd1, DW'(10 + i), 2'(i)})
                $display("FAIL b2b_beat1_%0d: got cmd=%0d data=%0d tag=%0d required cmd=1 data=%0d tag=%0d",
                         i, req_cmd_in, req_data_in, req_tag_in, 10 + i, i);
            else n_pass++;
            in_op1 = DW'(11 + i); in_op2 = DW'(21 + i);
            @(negedge c_clk);
            n_chk++;
            if ({req_cmd_in, req_data_in, req_tag_in} !== {4'd0, DW'(20 + i), 2'(i)})
                $display("FAIL b2b_beat2_%0d: got cmd=%0d data=%0d tag=%0d required cmd=0 data=%0d tag=%0d",
                         i, req_cmd_in, req_data_in, req_tag_in, 20 + i, i);
            else n_pass++;
            n_chk++;
            if (in_ready !== (i < 3))
                $display("FAIL b2b_ready_%0d: got %0d required %0d", i, in_ready, (i < 3));
            else n_pass++;
        end
        n_chk++;
        if (busy_cnt !== 3'd4) $display("FAIL b2b_busy_full: got %0d required 4", busy_cnt); else n_pass++;
        @(negedge c_clk);
        n_chk++;
        if (in_ready !== 1'b0 || req_cmd_in !== 4'd0)
            $display("FAIL b2b_stall: got ready=%0d cmd=%0d required 0 0", in_ready, req_cmd_in);
        else n_pass++;
        out_resp = 2'd1; out_data = 32'd99; out_tag = 2'd2;
        cpl_q.push_back({2'd1, 32'd99, 2'd2, 4'd1});
        @(negedge c_clk);
        out_resp = '0; out_data = '0; out_tag = '0;
        n_chk++;
        if (in_ready !== 1'b1 || busy_cnt !== 3'd3)
            $display("FAIL b2b_freed: got ready=%0d busy=%0d required 1 3", in_ready, busy_cnt);
        else n_pass++;
        @(negedge c_clk);
        in_valid = 1'b0;
        n_chk++;
        if ({req_cmd_in, req_data_in, req_tag_in} !== {4'd1, 32'd14, 2'd2})
            $display("FAIL b2b_fifth: got cmd=%0d data=%0d tag=%0d required cmd=1 data=14 tag=2",
                     req_cmd_in, req_data_in, req_tag_in);
        else n_pass++;
        @(negedge c_clk);
        send_resp(2'd1, 32'd100, 2'd0, 1'b1, 4'd1);
        send_resp(2'd2, 32'd101, 2'd1, 1'b1, 4'd1);
        send_resp(2'd1, 32'd103, 2'd3, 1'b1, 4'd1);
        send_resp(2'd1, 32'd102, 2'd2, 1'b1, 4'd1);
        n_chk++;
        if (busy_cnt !== 3'd0) $display("FAIL b2b_drained: got %0d required 0", busy_cnt); else n_pass++;
    endtask

    task automatic test_same_cycle_free();
        bit acc;
        logic [3:0] c1, c2; logic [DW-1:0] d1, d2; logic [1:0] t1, t2;
        logic [3:0] fill_cmd [4];
        fill_cmd[0] = 4'd1; fill_cmd[1] = 4'd5; fill_cmd[2] = 4'd6; fill_cmd[3] = 4'd2;
        for (int i = 0; i < 4; i++) begin
            send_op(fill_cmd[i], DW'(i), DW'(i), acc, c1, d1, t1, c2, d2, t2);
            n_chk++;
            if (acc !== 1'b1 || t1 !== 2'(i))
                $display("FAIL sc_fill_%0d: got acc=%0d tag=%0d required acc=1 tag=%0d", i, acc, t1, i);
            else n_pass++;
        end
        in_valid = 1'b1; in_cmd = 4'd2; in_op1 = 32'd50; in_op2 = 32'd3;
        out_resp = 2'd1; out_data = 32'd77; out_tag = 2'd1;
        cpl_q.push_back({2'd1, 32'd77, 2'd1, 4'd5});
        n_chk++;
        if (in_ready !== 1'b0) $display("FAIL sc_blocked: got ready=%0d required 0", in_ready); else n_pass++;
        @(negedge c_clk);
        out_resp = '0; out_data = '0; out_tag = '0;
        n_chk++;
        if (in_ready !== 1'b1 || busy_cnt !== 3'd3)
            $display("FAIL sc_unblocked: got ready=%0d busy=%0d required 1 3", in_ready, busy_cnt);
        else n_pass++;
        @(negedge c_clk);
        in_valid = 1'b0;
        n_chk++;
        if ({req_cmd_in, req_data_in, req_tag_in} !== {4'd2, 32'd50, 2'd1})
            $display("FAIL sc_reissue: got cmd=%0d data=%0d tag=%0d required cmd=2 data=50 tag=1",
                     req_cmd_in, req_data_in, req_tag_in);
        else n_pass++;
        @(negedge c_clk);
        send_resp(2'd1, 32'd1, 2'd0, 1'b1, 4'd1);
        send_resp(2'd1, 32'd47, 2'd1, 1'b1, 4'd2);
        send_resp(2'd1, 32'd2, 2'd2, 1'b1, 4'd6);
        send_resp(2'd2, 32'd3, 2'd3, 1'b1, 4'd2);
    endtask

    task automatic test_unexpected();
        send_resp(2'd1, 32'd5, 2'd3, 1'b0, 4'd0);
        n_chk++;
        if (err_unexp !== 1'b1) $display("FAIL unexp_set: got %0d required 1", err_unexp); else n_pass++;
        repeat (3) @(negedge c_clk);
        n_chk++;
        if (err_unexp !== 1'b1 || busy_cnt !== 3'd0)
            $display("FAIL unexp_sticky: got err=%0d busy=%0d required 1 0", err_unexp, busy_cnt);
        else n_pass++;
    endtask

    task automatic test_nop_and_invalid();
        bit acc;
        logic [3:0] c1, c2; logic [DW-1:0] d1, d2; logic [1:0] t1, t2;
        send_op(4'd0, 32'd11, 32'd22, acc, c1, d1, t1, c2, d2, t2);
        n_chk++;
        if (acc !== 1'b1 || {c1, d1, c2, d2} !== '0 || busy_cnt !== 3'd0)
            $display("FAIL nop_silent: got acc=%0d cmd=%0d data=%0d data2=%0d busy=%0d required acc=1 all 0",
                     acc, c1, d1, d2, busy_cnt);
        else n_pass++;
        send_op(4'd4, 32'd3, 32'd4, acc, c1, d1, t1, c2, d2, t2);
        n_chk++;
        if (acc !== 1'b1 || {c1, d1, t1, c2, d2, t2} !== {4'd4, 32'd3, 2'd0, 4'd0, 32'd4, 2'd0})
            $display("FAIL inv_issue: got cmd=%0d data=%0d tag=%0d data2=%0d required cmd=4 data=3 tag=0 data2=4",
                     c1, d1, t1, d2);
        else n_pass++;
        @(negedge c_clk);
        send_resp(2'd3, 32'd0, 2'd0, 1'b1, 4'd4);
    endtask

    task automatic test_reset_mid();
        bit acc;
        logic [3:0] c1, c2; logic [DW-1:0] d1, d2; logic [1:0] t1, t2;
        in_valid = 1'b1; in_cmd = 4'd1; in_op1 = 32'd8; in_op2 = 32'd9;
        @(negedge c_clk);
        in_valid = 1'b0;
        n_chk++;
        if (req_cmd_in !== 4'd1 || busy_cnt !== 3'd1)
            $display("FAIL mid_beat1: got cmd=%0d busy=%0d required 1 1", req_cmd_in, busy_cnt);
        else n_pass++;
        #2 reset = 1'b0;
        #1;
        n_chk++;
        if ({in_ready, req_cmd_in, req_data_in, req_tag_in, cpl_valid, busy_cnt, err_unexp} !== '0)
            $display("FAIL mid_reset_outputs: got ready=%0d cmd=%0d data=%0d busy=%0d err=%0d required all 0",
                     in_ready, req_cmd_in, req_data_in, busy_cnt, err_unexp);
        else n_pass++;
        repeat (2) @(negedge c_clk);
        reset = 1'b1;
        @(negedge c_clk);
        send_op(4'd1, 32'd1, 32'd2, acc, c1, d1, t1, c2, d2, t2);
        n_chk++;
        if (acc !== 1'b1 || t1 !== 2'd0 || c1 !== 4'd1)
            $display("FAIL mid_first_tag: got acc=%0d tag=%0d cmd=%0d required 1 0 1", acc, t1, c1);
        else n_pass++;
        @(negedge c_clk);
        send_resp(2'd1, 32'd3, 2'd0, 1'b1, 4'd1);
    endtask

    initial begin
        test_reset();
        test_single_add();
        test_back_to_back();
        test_same_cycle_free();
        test_unexpected();
        test_nop_and_invalid();
        test_reset_mid();
        repeat (2) @(negedge c_clk);
        n_chk++;
        if (cpl_q.size() != 0) $display("FAIL cpl_missing: got %0d pending required 0", cpl_q.size());
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/calc2_port_driver.md
# calc2_port_driver

Per-port request issuer and completion tracker sitting directly upstream of one calc2_top request port and consuming that port's response outputs. It accepts whole operations (command plus two operands) over a valid/ready handshake and allocates a free 2-bit tag. It serialises each operation into calc2's two-beat request protocol and retires tags as responses return, emitting one completion per response. Four instances, one per calc2 port, form the stimulus front end for the calc2 environment.

## Interface
- `DATA_W`, 32: operand/result width; must match calc2.
- `N_TAGS`, 4: tags per port; fixed by calc2's 2-bit tag.

- `c_clk` in 1: single clock; all state updates on rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `in_valid` in 1: operation offered.
- `in_ready` out 1: operation accepted when `in_valid && in_ready` at a rising edge.
- `in_cmd` in 4: calc2 command code (1 add, 2 sub, 5 shl, 6 shr; others passed through).
- `in_op1`, `in_op2` in DATA_W: operands.
- `req_cmd_in` out 4: to calc2 port.
- `req_data_in` out DATA_W: to calc2 port.
- `req_tag_in` out 2: to calc2 port.
- `out_resp` in 2: from calc2 (0 none, 1 ok, 2 overflow/underflow, 3 invalid cmd).
- `out_data` in DATA_W: from calc2.
- `out_tag` in 2: from calc2.
- `cpl_valid` out 1: one-cycle completion strobe; no backpressure.
- `cpl_resp` out 2, `cpl_data` out DATA_W, `cpl_tag` out 2, `cpl_cmd` out 4: completion fields; `cpl_cmd` is the command originally issued on that tag.
- `busy_cnt` out 3: outstanding tags, 0..4.
- `err_unexp` out 1: sticky; a response arrived on a tag not outstanding.

## Operation
- Reset asserted: every output is 0, FSM is IDLE, all tags are free. Cleared asynchronously, held until deassertion.
- FSM states:
  - IDLE: bus drives cmd 0, data 0, tag 0.
  - BEAT1: drives stored cmd, op1 and allocated tag.
  - BEAT2: drives cmd 0, op2 and the same tag.
- Transitions: IDLE/BEAT2 -> BEAT1 on accept of a nonzero cmd. BEAT1 -> BEAT2 always. BEAT2 -> IDLE with no accept.
- `in_ready` = (state != BEAT1) && (free tag exists). It is combinational from registered state.
- Accept with `in_cmd == 0`: operation is consumed and discarded. No tag is used, no bus activity, no completion.
- Tag allocation: lowest-numbered free tag. The tag is marked outstanding and its cmd is stored in a per-tag table.
- Response: `out_resp != 0` on an outstanding tag frees that tag. The next cycle raises `cpl_valid` with registered resp, data and tag, plus cmd from the table.
- Response on a non-outstanding tag: sets `err_unexp`. No completion, no state change.
- Invalid commands (e.g. 3, 4, 7+) are issued unchanged. The resp-3 completion is handled like any other.

## Timing
- Accept at edge N -> BEAT1 on bus during cycle N+1 -> BEAT2 during N+2.
- Peak throughput is one operation per 2 cycles, back-to-back (an accept during BEAT2 gives BEAT1 next cycle).
- Completion latency is 1 cycle after the response is sampled.
- A tag freed at edge N is allocatable from cycle N+1. Same-cycle allocate and free use the pre-edge free vector.
- `busy_cnt` updates at the same edge as allocation/free. Simultaneous alloc and free leave it unchanged.
- All four tags outstanding -> `in_ready` = 0 until a response frees one.
- Reset mid-operation: a pending BEAT2 is dropped and the tag table is cleared. calc2 shares the reset, so no stale responses are expected.

## Structure
- `calc2_pkg`: `cmd_e` (NOP=0, ADD=1, SUB=2, SHL=5, SHR=6), `resp_e` (NONE, OK, OVF, INV), `tag_t` (logic [1:0]), `N_TAGS`.
- Sub-module `calc2_tag_pool`: free vector, lowest-free priority encoder, alloc/free ports, count output.
- FSM, cmd table and completion register live in `calc2_port_driver`.

## Test plan
- Reset, then accept ADD op1=5 op2=7 -> beat1 cmd=1 data=5 tag=0, beat2 cmd=0 data=7 tag=0; respond resp=1 data=12 tag=0 -> next cycle cpl_valid=1, cpl_data=12, cpl_cmd=1, busy_cnt back to 0.
- Five operations offered back-to-back, no responses -> tags 0,1,2,3 issued 2 cycles apart; `in_ready` low after fourth; busy_cnt=4; respond tag 2 -> fifth op issues on tag 2.
- Response tag 1 in same cycle as an accept while only tag 1 was free -> accept blocked that cycle (`in_ready` 0); issues on tag 1 next cycle.
- Response resp=1 on idle tag 3 -> err_unexp=1 and stays set; no cpl_valid.
- Accept cmd 0 -> no bus activity, busy_cnt unchanged. Accept cmd 4 -> issued, resp=3 completion with cpl_cmd=4.
- Assert reset during BEAT1 -> all outputs 0 immediately; after release, first op uses tag 0.
